// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU UART command link: header bytes and
// the master state encoding.
package alu_uart_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HDR_A  = 8'h01;
    localparam logic [BYTE_W-1:0] HDR_B  = 8'h02;
    localparam logic [BYTE_W-1:0] HDR_OP = 8'h03;
    localparam logic [BYTE_W-1:0] HDR_R  = 8'h04;

    localparam int unsigned          IDX_W    = 3;
    localparam logic [IDX_W-1:0]     LAST_IDX = 3'd6;

    typedef logic [1:0] mst_state_t;

    localparam mst_state_t ST_IDLE    = 2'd0;
    localparam mst_state_t ST_LOAD    = 2'd1;
    localparam mst_state_t ST_WAIT_TX = 2'd2;
    localparam mst_state_t ST_WAIT_RX = 2'd3;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Cycle counter for link masters: flags the cycle in which the count being
// registered reaches TIMEOUT-1, so the caller's registered pulse lands
// exactly TIMEOUT cycles after the clear.
module cmd_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired_c = i_enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/alu_cmd_master.sv
// Host-side ALU command initiator: sends HDR_A,A,HDR_B,B,HDR_OP,OP,HDR_R
// through a UART TX core, then waits (with timeout) for one result byte.
module alu_cmd_master #(
    parameter int unsigned  N       = 8,
    parameter logic [N-1:0] HDR_A   = N'(alu_uart_pkg::HDR_A),
    parameter logic [N-1:0] HDR_B   = N'(alu_uart_pkg::HDR_B),
    parameter logic [N-1:0] HDR_OP  = N'(alu_uart_pkg::HDR_OP),
    parameter logic [N-1:0] HDR_R   = N'(alu_uart_pkg::HDR_R),
    parameter int unsigned  TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    input  logic [N-1:0] i_op,
    output logic [N-1:0] o_tx_data,
    output logic         o_tx_start,
    input  logic         i_tx_done,
    input  logic [N-1:0] i_rx_data,
    input  logic         i_rx_valid,
    output logic [N-1:0] o_result,
    output logic         o_result_valid,
    output logic         o_timeout,
    output logic         o_busy
);

    import alu_uart_pkg::*;

    mst_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, op_q, op_d;
    logic [N-1:0]     tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic [N-1:0]     result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             done_ok_c;
    logic             last_byte_c;
    logic             ctr_clear_c;
    logic             ctr_en_c;
    logic             expired_c;
    logic [N-1:0]     cur_byte_c;

    // A done pulse alongside our own start pulse cannot belong to this byte.
    assign done_ok_c   = i_tx_done && !tx_start_q;
    assign last_byte_c = (idx_q == LAST_IDX);
    assign ctr_clear_c = (state_q == ST_WAIT_TX) && done_ok_c && last_byte_c;
    assign ctr_en_c    = (state_q == ST_WAIT_RX);

    cmd_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (ctr_clear_c),
        .i_enable    (ctr_en_c),
        .o_expired_c (expired_c)
    );

    always_comb begin
        case (idx_q)
            IDX_W'(0): cur_byte_c = HDR_A;
            IDX_W'(1): cur_byte_c = a_q;
            IDX_W'(2): cur_byte_c = HDR_B;
            IDX_W'(3): cur_byte_c = b_q;
            IDX_W'(4): cur_byte_c = HDR_OP;
            IDX_W'(5): cur_byte_c = op_q;
            IDX_W'(6): cur_byte_c = HDR_R;
            default:   cur_byte_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (idx_q <= LAST_IDX) ? ST_WAIT_TX : ST_IDLE;
            end
            ST_WAIT_TX: begin
                if (done_ok_c) begin
                    state_d = last_byte_c ? ST_WAIT_RX : ST_LOAD;
                end
            end
            ST_WAIT_RX: begin
                if (i_rx_valid || expired_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d          = idx_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;
        busy_d         = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d   = i_A;
                    b_d   = i_B;
                    op_d  = i_op;
                    idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (idx_q <= LAST_IDX) begin
                    tx_data_d  = cur_byte_c;
                    tx_start_d = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (done_ok_c && !last_byte_c) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_WAIT_RX: begin
                // A result arriving in the expiry cycle takes precedence.
                if (i_rx_valid) begin
                    result_d       = i_rx_data;
                    result_valid_d = 1'b1;
                end else if (expired_c) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign o_tx_data      = tx_data_q;
    assign o_tx_start     = tx_start_q;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_timeout      = timeout_q;
    assign o_busy         = busy_q;

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Host-side initiator for the ALU UART command protocol; drives the opposite end of the link from the ALU command interface.
- On a start pulse it latches operands A, B and OP, then transmits seven bytes in order through a UART TX core: 0x01, A, 0x02, B, 0x03, OP, 0x04 (result request).
- It then waits for one result byte from a UART RX core and returns it to the local requester, with a timeout guard.
- Sits between test/host logic and the uart_tx/uart_rx pair.

Parameters:
- N, 8, data/byte width.
- HDR_A, 8'h01, header byte preceding operand A.
- HDR_B, 8'h02, header byte preceding operand B.
- HDR_OP, 8'h03, header byte preceding opcode.
- HDR_R, 8'h04, result-request byte.
- TIMEOUT, 1000000, clock cycles to wait for the result byte after HDR_R completes; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle request to run a transaction; ignored while o_busy=1.
- i_A  in  N  operand A, sampled only in the i_start cycle.
- i_B  in  N  operand B, sampled only in the i_start cycle.
- i_op  in  N  opcode, sampled only in the i_start cycle.
- o_tx_data  out  N  byte presented to the UART TX core.
- o_tx_start  out  1  one-cycle pulse: TX core loads o_tx_data.
- i_tx_done  in  1  one-cycle pulse from the TX core: byte fully shifted out.
- i_rx_data  in  N  byte from the UART RX core.
- i_rx_valid  in  1  one-cycle pulse: i_rx_data is valid.
- o_result  out  N  last result byte received; held until the next one.
- o_result_valid  out  1  one-cycle pulse when o_result updates.
- o_timeout  out  1  one-cycle pulse when the result wait expires.
- o_busy  out  1  high from the cycle after an accepted i_start until return to IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE and the byte index to 0.
  - All outputs go to 0: o_tx_data, o_tx_start, o_result, o_result_valid, o_timeout, o_busy.
  - Latched operands are cleared.
  - Reset asserted mid-transaction aborts it; no completion pulse is produced after reset is released.
- All outputs are registered.
- States:
  - IDLE: o_busy=0. On i_start=1, latch A/B/OP, set idx=0, go to LOAD.
  - LOAD: set o_tx_data = byte[idx] (idx 0..6 maps to HDR_A, A, HDR_B, B, HDR_OP, OP, HDR_R). Pulse o_tx_start for exactly one cycle. Go to WAIT_TX.
  - WAIT_TX:
    - o_tx_data is held stable.
    - i_tx_done is honoured only in this state; a pulse coinciding with the LOAD cycle is ignored.
    - On i_tx_done with idx<6: idx<=idx+1, go to LOAD.
    - On i_tx_done with idx==6: clear the timeout counter, go to WAIT_RX.
  - WAIT_RX:
    - Counter increments every cycle.
    - On i_rx_valid: o_result<=i_rx_data, pulse o_result_valid, go to IDLE.
    - Else when the counter reaches TIMEOUT-1: pulse o_timeout, leave o_result unchanged, go to IDLE.
    - i_rx_valid in the same cycle as expiry: the result wins and o_timeout is not pulsed.
- Latency: first o_tx_start occurs 2 cycles after the i_start cycle. Each subsequent o_tx_start occurs 2 cycles after the preceding i_tx_done.
- i_rx_valid outside WAIT_RX is ignored (stale/echo bytes are dropped).
- i_start while busy is dropped, not queued.
- A new i_start is accepted in the IDLE cycle immediately after a completion pulse.
- Counter width: $clog2(TIMEOUT)+1. No wrap is possible, because expiry exits the state.
- idx is 3 bits; values 7 and above are unreachable, and the default branch returns to IDLE.

Decomposition:
- Shared package alu_uart_pkg:
  - Header constants HDR_A/HDR_B/HDR_OP/HDR_R; these are also consumed by the ALU-side command interface.
  - Master state encoding localparams (IDLE, LOAD, WAIT_TX, WAIT_RX).
- One natural sub-module: cmd_timeout_ctr.
  - Inputs: clear, enable.
  - Output: expired pulse.
  - Parameterised by TIMEOUT; reused by other link masters.

Test Plan:
- Reset, then i_start with A=0x12, B=0x34, op=0x20.
  - TX model returns i_tx_done 10 cycles after each o_tx_start.
  - Required: exactly 7 o_tx_start pulses carrying 01,12,02,34,03,20,04 in order.
  - RX model then returns 0x46 → o_result=0x46 with a single o_result_valid pulse; o_busy falls the next cycle.
- TIMEOUT=50, no RX byte after the 7th i_tx_done.
  - Required: o_timeout pulses exactly 50 cycles later; o_result keeps its previous value; o_result_valid stays 0.
- TIMEOUT=50, i_rx_valid with 0x99 in the expiry cycle.
  - Required: o_result=0x99, o_result_valid=1, o_timeout=0.
- i_rx_valid=1 with 0x55 during WAIT_TX of byte 3, plus a second i_start mid-transaction.
  - Required: both are ignored; byte sequence and final result are unchanged.
- Assert rst during WAIT_TX of byte 4 (asynchronous, mid-cycle).
  - Required: o_tx_start, o_busy and o_tx_data are 0 immediately.
  - After release: no further o_tx_start until a new i_start, and that transaction restarts from HDR_A.
- i_tx_done pulsed in the same cycle as o_tx_start.
  - Required: that pulse is ignored; the block advances only on the next i_tx_done.
